// File: rtl/xout_rr_arbiter.sv
// Round-robin arbiter that is the sole writer of the shared XOUT register.
// The winner's DATA is latched and held for HOLD cycles; all state changes on the falling edge of CLK.
module xout_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int HOLD  = 2
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [NREQ-1:0]            REQ,
    input  logic [NREQ*WIDTH-1:0]      DATA,
    output logic [NREQ-1:0]            ACK,
    output logic [WIDTH-1:0]           XOUT,
    output logic                       XVALID,
    output logic [$clog2(NREQ)-1:0]    GRANT,
    output logic                       BUSY
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    if ((NREQ < 2) || (NREQ > 8) || (HOLD < 1)) begin : g_param_check
        $error("xout_rr_arbiter: NREQ must be 2..8 and HOLD must be >= 1");
    end

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [GW-1:0]       ptr;
    logic [GW-1:0]       ptr_nxt;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_nxt;
    logic [NREQ-1:0]     ack_nxt;
    logic [WIDTH-1:0]    xout_nxt;
    logic [GW-1:0]       grant_nxt;

    logic                found;
    logic [GW-1:0]       win_idx;
    logic [WIDTH-1:0]    data_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign data_arr[g] = DATA[g*WIDTH +: WIDTH];
    end

    // Scan upward from ptr, wrapping modulo NREQ; the first requester found wins.
    always_comb begin
        logic [GW:0]   sum;
        logic [GW-1:0] cand;
        found   = 1'b0;
        win_idx = '0;
        sum     = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (GW+1)'(k);
            if (sum >= (GW+1)'(NREQ)) begin
                sum = sum - (GW+1)'(NREQ);
            end
            cand = sum[GW-1:0];
            if (!found && REQ[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_ff @(negedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (found) state_nxt = S_HOLD;
            S_HOLD: if (cnt == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ack_nxt   = '0;
        xout_nxt  = XOUT;
        grant_nxt = GRANT;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        unique case (state)
            S_IDLE: begin
                if (found) begin
                    ack_nxt[win_idx] = 1'b1;
                    xout_nxt         = data_arr[win_idx];
                    grant_nxt        = win_idx;
                    ptr_nxt          = (win_idx == GW'(NREQ-1)) ? '0 : win_idx + 1'b1;
                    cnt_nxt          = CW'(HOLD-1);
                end
            end
            S_HOLD: begin
                if (cnt != '0) cnt_nxt = cnt - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(negedge CLK) begin
        if (RESET) begin
            ACK   <= '0;
            XOUT  <= '0;
            GRANT <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            ACK   <= ack_nxt;
            XOUT  <= xout_nxt;
            GRANT <= grant_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // XVALID and BUSY coincide with the HOLD state, which lasts exactly HOLD cycles.
    assign XVALID = (state == S_HOLD);
    assign BUSY   = (state == S_HOLD);

endmodule
